// File: rtl/mips_run_ctrl_if.sv
// Host command port of the MIPS run/debug controller: valid/ready handshake
// plus opcode, address, data and a one-cycle reject pulse.
interface mips_run_ctrl_if;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [2:0]  cmd_op;
  logic [31:0] cmd_addr;
  logic [31:0] cmd_data;
  logic        cmd_err;

  modport master (
    output cmd_valid, cmd_op, cmd_addr, cmd_data,
    input  cmd_ready, cmd_err
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_addr, cmd_data,
    output cmd_ready, cmd_err
  );
endinterface

// File: rtl/mips_run_ctrl.sv
// Run/debug sequencer for the monocycle MIPS datapath: imem loading under reset,
// budgeted run, single step, halt, one PC breakpoint and a retired counter.
module mips_run_ctrl #(
  parameter int IMEM_AW = 8,
  parameter int CNT_W   = 16
) (
  input  logic               clk,
  input  logic               rst,
  mips_run_ctrl_if.slave     cmd,
  input  logic [31:0]        core_pc,
  output logic               core_rst,
  output logic               core_en,
  output logic               imem_we,
  output logic [IMEM_AW-1:0] imem_waddr,
  output logic [31:0]        imem_wdata,
  output logic [2:0]         state,
  output logic               halted,
  output logic               bp_hit,
  output logic [CNT_W-1:0]   retired
);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOAD   = 3'd1,
    ST_RUN    = 3'd2,
    ST_STEP   = 3'd3,
    ST_HALTED = 3'd4
  } state_t;

  localparam logic [2:0] OP_LOAD  = 3'd1;
  localparam logic [2:0] OP_RUN   = 3'd2;
  localparam logic [2:0] OP_STEP  = 3'd3;
  localparam logic [2:0] OP_HALT  = 3'd4;
  localparam logic [2:0] OP_SETBP = 3'd5;

  localparam logic [CNT_W-1:0] BUDGET_LAST = CNT_W'(1);

  state_t             state_reg;
  logic               core_rst_reg;
  logic               imem_we_reg;
  logic [IMEM_AW-1:0] imem_waddr_reg;
  logic [31:0]        imem_wdata_reg;
  logic               cmd_err_reg;
  logic               bp_hit_reg;
  logic [CNT_W-1:0]   retired_reg;
  logic [31:0]        bp_addr_reg;
  logic               bp_en_reg;
  logic [CNT_W-1:0]   budget_reg;
  logic               skip_reg;

  logic accept;
  logic bp_match;

  assign accept   = cmd.cmd_valid && cmd.cmd_ready;
  // skip masks the breakpoint on the first cycle after resuming from it
  assign bp_match = bp_en_reg && (core_pc == bp_addr_reg) && !skip_reg;

  always_comb begin
    core_en = 1'b0;
    case (state_reg)
      ST_RUN:  core_en = !bp_match;
      ST_STEP: core_en = 1'b1;
      default: core_en = 1'b0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg      <= ST_IDLE;
      core_rst_reg   <= 1'b1;
      imem_we_reg    <= 1'b0;
      imem_waddr_reg <= '0;
      imem_wdata_reg <= '0;
      cmd_err_reg    <= 1'b0;
      bp_hit_reg     <= 1'b0;
      retired_reg    <= '0;
      bp_addr_reg    <= '0;
      bp_en_reg      <= 1'b0;
      budget_reg     <= '0;
      skip_reg       <= 1'b0;
    end else begin
      imem_we_reg <= 1'b0;
      cmd_err_reg <= 1'b0;

      if (core_en) begin
        if (retired_reg != '1)
          retired_reg <= retired_reg + 1'b1;
        skip_reg <= 1'b0;
        if (budget_reg != '0)
          budget_reg <= budget_reg - 1'b1;
      end

      if (accept && cmd.cmd_op == OP_SETBP) begin
        bp_addr_reg <= cmd.cmd_addr;
        bp_en_reg   <= cmd.cmd_data[0];
      end

      case (state_reg)
        ST_IDLE, ST_HALTED: begin
          if (accept) begin
            case (cmd.cmd_op)
              OP_LOAD: begin
                state_reg      <= ST_LOAD;
                imem_we_reg    <= 1'b1;
                imem_waddr_reg <= cmd.cmd_addr[IMEM_AW+1:2];
                imem_wdata_reg <= cmd.cmd_data;
                core_rst_reg   <= 1'b1;
                bp_hit_reg     <= 1'b0;
              end
              OP_RUN: begin
                state_reg    <= ST_RUN;
                core_rst_reg <= 1'b0;
                budget_reg   <= cmd.cmd_data[CNT_W-1:0];
                bp_hit_reg   <= 1'b0;
                if (state_reg == ST_IDLE)
                  retired_reg <= '0;
                else
                  skip_reg <= 1'b1;
              end
              OP_STEP: begin
                state_reg    <= ST_STEP;
                core_rst_reg <= 1'b0;
                bp_hit_reg   <= 1'b0;
                if (state_reg == ST_IDLE)
                  retired_reg <= '0;
              end
              OP_SETBP: ;
              default: cmd_err_reg <= 1'b1;
            endcase
          end
        end
        ST_LOAD: state_reg <= ST_IDLE;
        ST_RUN: begin
          if (accept && cmd.cmd_op != OP_SETBP && cmd.cmd_op != OP_HALT)
            cmd_err_reg <= 1'b1;
          if (bp_match) begin
            state_reg  <= ST_HALTED;
            bp_hit_reg <= 1'b1;
          end else if (accept && cmd.cmd_op == OP_HALT) begin
            state_reg <= ST_HALTED;
          end else if (budget_reg == BUDGET_LAST) begin
            state_reg <= ST_HALTED;
          end
        end
        ST_STEP: state_reg <= ST_HALTED;
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

  generate
    if (CNT_W < 32) begin : g_data_sink
      logic data_unused;
      assign data_unused = ^cmd.cmd_data[31:CNT_W];
    end
  endgenerate

  assign cmd.cmd_ready = (state_reg != ST_LOAD) && (state_reg != ST_STEP);
  assign cmd.cmd_err   = cmd_err_reg;
  assign core_rst      = core_rst_reg;
  assign imem_we       = imem_we_reg;
  assign imem_waddr    = imem_waddr_reg;
  assign imem_wdata    = imem_wdata_reg;
  assign state         = state_reg;
  assign halted        = (state_reg == ST_HALTED);
  assign bp_hit        = bp_hit_reg;
  assign retired       = retired_reg;

endmodule
